ntt_bfly_addsub: RTL and testbench

NTT_BFLY_ADDSUB -- requirements
Module: ntt_bfly_addsub

---
 rtl/ntt_bfly_addsub.sv | 163 ++++++++++++++++
 tb/tb_ntt_bfly_addsub.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bfly_addsub.sv
// ntt_bfly_addsub
//   Add/subtract half of an NTT butterfly. Takes coefficient a and the
//   already-reduced twiddle product t and produces (a+t) mod q and
//   (a-t) mod q through a two-stage valid/ready pipeline.
//
//   Stage 1 registers the raw sum a+t and the raw difference a+q-t
//   (WIDTH+1 bits each). Stage 2 registers each value after one
//   conditional subtraction of q.
//
// Parameters
//   The modulus q and the coefficient width in bits.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair present
//   in_ready   pair accepted this cycle
//   in_a       top coefficient a
//   in_t       reduced twiddle product t
//   out_valid  result pair present
//   out_ready  downstream accepts result
//   out_sum    (a+t) mod q
//   out_diff   (a-t) mod q
//   busy       any stage holds valid data
//   op_count   completed output handshakes, wraps at 16 bits
//   range_err  sticky flag: an accepted operand was >= q
//              (present only when BFLY_RANGE_CHECK_EN is defined)
//
// Build option
//   BFLY_RANGE_CHECK_EN  adds the range_err port and its sticky flag.

module ntt_bfly_addsub #(
  parameter int MOD   = 3329,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_diff,
  output logic             busy,
  output logic [15:0]      op_count
`ifdef BFLY_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MOD);

  // One conditional subtraction; exact whenever the input is below 2*MOD.
  function automatic logic [WIDTH-1:0] reduce_once(input logic [WIDTH:0] x);
    logic [WIDTH:0] r;
    r = (x >= MOD_X) ? (x - MOD_X) : x;
    return WIDTH'(r);
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   s1_sum_q,   s1_sum_d;
  logic [WIDTH:0]   s1_diff_q,  s1_diff_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_sum_q,   s2_sum_d;
  logic [WIDTH-1:0] s2_diff_q,  s2_diff_d;
  logic [15:0]      op_count_q, op_count_d;

  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s2_adv || !s1_valid_q;
    in_fire  = in_valid && s1_adv;
    out_fire = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_diff_d  = s1_diff_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_diff_d  = s2_diff_q;
    op_count_d = op_count_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_sum_d  = {1'b0, in_a} + {1'b0, in_t};
      // Adding MOD before subtracting keeps the difference non-negative
      // for in-range operands.
      s1_diff_d = {1'b0, in_a} + MOD_X - {1'b0, in_t};
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      // Data only moves when there is something to move, so an emptied
      // output keeps its last value rather than loading stale stage-1 data.
      if (s1_valid_q) begin
        s2_sum_d  = reduce_once(s1_sum_q);
        s2_diff_d = reduce_once(s1_diff_q);
      end
    end

    if (out_fire) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_diff_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_diff_q  <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_diff_q  <= s1_diff_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_diff_q  <= s2_diff_d;
      op_count_q <= op_count_d;
    end
  end

`ifdef BFLY_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  always_comb begin
    range_err_d = range_err_q;
    if (in_fire && (({1'b0, in_a} >= MOD_X) || ({1'b0, in_t} >= MOD_X))) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;
`endif

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_diff  = s2_diff_q;
  assign busy      = s1_valid_q || s2_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_ntt_bfly_addsub.sv
module tb_ntt_bfly_addsub;

  localparam int MOD   = 3329;
  localparam int WIDTH = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_t = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic [WIDTH-1:0] out_diff;
  logic             busy;
  logic [15:0]      op_count;
`ifdef BFLY_RANGE_CHECK_EN
  logic             range_err;
`endif

  ntt_bfly_addsub #(.MOD(MOD), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_diff  (out_diff),
    .busy      (busy),
    .op_count  (op_count)
`ifdef BFLY_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int d;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc    = 0;
  int          n_out    = 0;
  logic [15:0] exp_ops  = '0;
  bit          drv_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: raw sum and a+MOD-t in WIDTH+1 bits, then one
  // conditional subtraction of MOD, truncated to WIDTH bits.
  function automatic exp_t model(input int a, input int t);
    exp_t e;
    int s, d;
    s = a + t;
    if (s >= MOD) s = s - MOD;
    d = a + MOD - t;
    if (d < 0) d = d + (1 << (WIDTH + 1));
    if (d >= MOD) d = d - MOD;
    e.s = s % (1 << WIDTH);
    e.d = d % (1 << WIDTH);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(int'(in_a), int'(in_t)));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 0, 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_sum", out_sum, e.s);
          check("out_diff", out_diff, e.d);
        end
        exp_ops = exp_ops + 16'd1;
        n_out++;
      end
    end
  end

  task automatic send(input int a, input int t);
    int k;
    in_valid = 1'b1;
    in_a     = WIDTH'(a);
    in_t     = WIDTH'(t);
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 500) begin
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef BFLY_RANGE_CHECK_EN
    check("rst_range_err", range_err, 0);
`endif
    sb.delete();
    exp_ops = '0;
    @(posedge clk);
    #1;
    check("rst_out_sum", out_sum, 0);
    check("rst_out_diff", out_diff, 0);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((!drv_done || sb.size() != 0) && k < 80000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, (k < 80000), 1);
  endtask

  initial begin
    int a_tab[6];
    int t_tab[6];
    int k0;

    // Reset with a pair in flight from time zero is not possible; start clean.
    do_reset();

    // Pair driven right after rst deasserts, captured on the first edge,
    // visible after the second edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 12'd3000;
    in_t      = 12'd500;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_first_accept", n_acc, 1);
    check("lat_e1_out_valid", out_valid, 0);
    check("lat_e1_busy", busy, 1);
    @(posedge clk);
    #1;
    check("lat_e2_out_valid", out_valid, 1);
    check("lat_e2_sum", out_sum, 171);
    check("lat_e2_diff", out_diff, 2500);
    check("lat_e2_op_count", op_count, 0);
    @(posedge clk);
    #1;
    check("lat_e3_op_count", op_count, 1);
    check("lat_e3_out_valid", out_valid, 0);
    check("lat_e3_busy", busy, 0);

    // Directed corner vectors streamed back-to-back.
    a_tab = '{5, 3328, 0, 3328, 0, 1664};
    t_tab = '{10, 3328, 0, 0, 3328, 1665};
    drv_done = 1'b0;
    for (int i = 0; i < 6; i++) send(a_tab[i], t_tab[i]);
    drv_done = 1'b1;
    wait_drain("vec_drain");
    check("vec_op_count", op_count, exp_ops);

    // Random in-range pairs against random downstream backpressure.
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
        drv_done = 1'b1;
      end
    join_none
    k0 = 0;
    while ((!drv_done || sb.size() != 0) && k0 < 5000) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      k0++;
    end
    check("rand_drain", (k0 < 5000), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rand_op_count", op_count, exp_ops);

    // Reset while two pairs are in flight: outputs clear immediately and
    // nothing stale appears afterwards.
    out_ready = 1'b0;
    send(11, 22);
    send(33, 44);
    check("mid_busy", busy, 1);
    check("mid_op_count_nonzero", (op_count != 0), 1);
    do_reset();
    out_ready = 1'b1;
    k0 = n_out;
    repeat (5) @(posedge clk);
    #1;
    check("mid_no_stale", n_out - k0, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_busy_after", busy, 0);

    // Backpressure: 5 pairs offered back-to-back, downstream stalled 4 cycles.
    n_acc    = 0;
    k0       = n_out;
    out_ready = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(100 * i + 7, 3000 - 50 * i);
        drv_done = 1'b1;
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold_sum", out_sum, sb[0].s);
      check("stall_hold_diff", out_diff, sb[0].d);
      @(posedge clk);
      #1;
    end
    check("stall_accepts", n_acc, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stream_one_per_cycle", n_out - k0, c + 1);
    end
    wait_drain("stall_drain");
    check("stall_op_count", op_count, 5);
    check("stall_op_model", op_count, exp_ops);

`ifdef BFLY_RANGE_CHECK_EN
    check("rerr_clear", range_err, 0);
    send(3329, 0);
    check("rerr_set", range_err, 1);
    send(12, 34);
    send(56, 78);
    repeat (3) @(posedge clk);
    #1;
    check("rerr_sticky", range_err, 1);
    do_reset();
    @(posedge clk);
    #1;
    check("rerr_after_rst", range_err, 0);
`endif

    // Counter wrap: 65535 handshakes, then one more.
    do_reset();
    out_ready = 1'b1;
    drv_done  = 1'b0;
    for (int i = 0; i < 65535; i++) send(i % MOD, (i * 7) % MOD);
    drv_done = 1'b1;
    wait_drain("wrap_drain1");
    check("wrap_65535", op_count, 65535);
    send(1, 2);
    wait_drain("wrap_drain2");
    check("wrap_zero", op_count, 0);
    check("wrap_model", op_count, exp_ops);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
